flash_boot_loader: RTL and testbench
====================================

# flash_boot_loader

Boot-time sequencer that copies a program image from the external SPI flash into PRAM, then releases the CPU. It sits in `cpu_top` between the flash pins and the PRAM write port. While it owns PRAM it holds the fetch/decode pipeline. It issues a standard SPI READ (0x03) with a 24-bit address, streams `LOAD_BYTES` bytes into PRAM starting at address 0, and deasserts `cpu_hold` when the last byte is written.

## Interface
- `PRAM_AW`, 8: PRAM address width.
- `LOAD_BYTES`, 256: bytes copied. Legal range is 1..2^PRAM_AW.
- `FLASH_BASE`, 24'h000000: flash start address sent after the command byte.
- `CLK_DIV`, 2: `flash_clk` half-period, in `sys_clk` cycles. Must be ≥2.

Ports:
- `sys_clk` in 1: only clock; all logic on its rising edge.
- `rst` in 1: synchronous, active-high reset.
- `start` in 1: one-cycle load request (already synchronised from btn2).
- `flash_MISO` in 1: serial data from flash.
- `flash_MOSI` out 1: serial data to flash.
- `flash_clk` out 1: SPI clock, mode 0.
- `flash_cs` out 1: flash chip select, active low.
- `pram_wr_en` out 1: one-cycle PRAM write strobe.
- `pram_wr_addr` out PRAM_AW: PRAM write address.
- `pram_wr_data` out 8: byte to write.
- `cpu_hold` out 1: high = CPU stalled (PC/decoder frozen, PRAM port owned by loader).
- `busy` out 1: high while in CMD or READ.
- `done` out 1: high in DONE until the next load or reset.

## Operation
- States and transitions:
  - IDLE → CMD on `start`.
  - CMD → READ after 32 bits are shifted.
  - READ → DONE after `LOAD_BYTES` bytes.
  - DONE → CMD on `start` (reload).
- Reset values:
  - state IDLE
  - `flash_cs`=1, `flash_clk`=0, `flash_MOSI`=0
  - `pram_wr_en`=0, `pram_wr_addr`=0, `pram_wr_data`=0
  - `cpu_hold`=1, `busy`=0, `done`=0
  - all counters 0
- `cpu_hold` is 1 in IDLE, CMD and READ; 0 only in DONE.
- Entering CMD from DONE re-asserts `cpu_hold` and clears `done`.
- `start` in CMD or READ is ignored.
- CMD shifts the 32-bit word {8'h03, FLASH_BASE}, MSB first.
- `flash_MOSI` is driven low throughout READ.
- SPI mode 0:
  - `flash_clk` idles low.
  - `flash_MOSI` changes on the edge where `flash_clk` falls, and on CMD entry.
  - `flash_MISO` is sampled on the edge where `flash_clk` rises.
- Bytes are assembled MSB first.
- Byte k (0-based) is written to `pram_wr_addr`=k.
- The address counter is PRAM_AW wide. With `LOAD_BYTES`=2^PRAM_AW it wraps to 0 after the final write, and nothing is written past the last byte.
- Reset mid-load:
  - next edge returns to IDLE, `flash_cs`=1, `flash_clk`=0, `cpu_hold`=1.
  - the partial byte is discarded and no further writes occur.
  - a later `start` restarts from the command and PRAM address 0.
- `rst` and `start` in the same cycle: `rst` wins.

## Timing
- `start` sampled high at edge t: at edge t+1 `flash_cs`=0, `busy`=1, and `flash_MOSI` = command bit 31.
- Half-period counter:
  - counts 0..CLK_DIV-1.
  - `flash_clk` toggles on the edge where it reaches CLK_DIV-1, then the counter reloads 0.
  - first rising edge is at t+1+CLK_DIV; one SPI bit lasts 2·CLK_DIV cycles.
- Write strobe: `pram_wr_en` is a 1-cycle pulse on the edge after the 8th rising-edge sample of each byte, with data and address valid in the same cycle.
- Since CLK_DIV ≥ 2, each write completes before the next byte's first sample.
- Completion, with B = 32+8·LOAD_BYTES:
  - after the final rising sample, the next falling point (edge t+1+2·CLK_DIV·B) drives `flash_clk`=0, `flash_cs`=1.
  - on that same edge: `busy`=0, `done`=1, `cpu_hold`=0.
- `flash_cs` stays low continuously from CMD entry to completion; there are no gaps between bytes.

## Test plan
- Reset values: hold `rst` 4 cycles → all outputs at their reset values, `cpu_hold`=1, no `flash_clk` toggles.
- Full load (LOAD_BYTES=8, CLK_DIV=2, FLASH_BASE=0, flash model returns byte i = i^8'hA5):
  - MOSI carries 0x03000000.
  - 8 strobes occur: addr 0..7, data A5,A4,A7,A6,A1,A0,A3,A2.
  - `done`/`cpu_hold`=0 exactly at start+385.
- Busy start: pulse `start` again mid-READ → exactly 8 strobes, same completion cycle.
- Reset mid-READ after 3 bytes:
  - `flash_cs`=1 next edge, `cpu_hold`=1, no more strobes.
  - new `start` → MOSI resends 0x03000000 and writes begin at addr 0.
- Reload from DONE: `start` while `done`=1 → `cpu_hold`=1 next edge, full 8-byte reload, `done` again at +385.
- CLK_DIV=3, FLASH_BASE=24'h012340:
  - `flash_clk` period is 6 cycles.
  - MOSI = 0x03012340.
  - first rising edge at start+4.

Source files
------------

// File: rtl/flash_boot_loader.sv
// flash_boot_loader
//
// Boot-time sequencer. After a load request it reads a program image out of
// the external SPI flash (mode 0, standard READ command 0x03 plus a 24-bit
// address) and writes it byte by byte into PRAM, starting at address 0.
// The CPU is held for the whole load, and is released once the last byte
// has been written.
//
// Ports:
//   sys_clk       only clock; everything runs on its rising edge
//   rst           synchronous active-high reset
//   start         one-cycle load request; ignored while a load is running
//   flash_MISO    serial data from the flash
//   flash_MOSI    serial data to the flash (command, then held low)
//   flash_clk     SPI clock, idles low
//   flash_cs      flash chip select, active low
//   pram_wr_en    one-cycle PRAM write strobe
//   pram_wr_addr  PRAM write address (also the running byte address counter)
//   pram_wr_data  byte being written
//   cpu_hold      high while the loader owns PRAM and the CPU is frozen
//   busy          high while sending the command or reading data
//   done          high once the image is loaded, until the next load or reset
module flash_boot_loader #(
  parameter int          PRAM_AW    = 8,
  parameter int          LOAD_BYTES = 256,
  parameter logic [23:0] FLASH_BASE = 24'h000000,
  parameter int          CLK_DIV    = 2
) (
  input  logic               sys_clk,
  input  logic               rst,
  input  logic               start,
  input  logic               flash_MISO,
  output logic               flash_MOSI,
  output logic               flash_clk,
  output logic               flash_cs,
  output logic               pram_wr_en,
  output logic [PRAM_AW-1:0] pram_wr_addr,
  output logic [7:0]         pram_wr_data,
  output logic               cpu_hold,
  output logic               busy,
  output logic               done
);

  localparam int DIV_W  = $clog2(CLK_DIV);
  localparam int BYTE_W = PRAM_AW + 1;

  localparam logic [DIV_W-1:0]  DIV_LAST  = DIV_W'(CLK_DIV - 1);
  localparam logic [BYTE_W-1:0] LAST_BYTE = BYTE_W'(LOAD_BYTES - 1);
  localparam logic [31:0]       CMD_WORD  = {8'h03, FLASH_BASE};

  typedef enum logic [1:0] {
    IDLE,
    CMD,
    READ,
    DONE
  } state_t;

  state_t              state;
  logic                start_q;
  logic [DIV_W-1:0]    div_cnt;
  logic [5:0]          bit_cnt;
  logic [31:0]         cmd_shift;
  logic [7:0]          rx_shift;
  logic [2:0]          rx_bits;
  logic [BYTE_W-1:0]   byte_cnt;
  logic                byte_ready;
  logic                last_byte;

  // The whole loader is one registered FSM. The load request is registered
  // once, so the flash transaction begins on the edge after start is seen.
  // While a transaction runs, div_cnt paces flash_clk: every CLK_DIV cycles
  // the clock toggles. A rising toggle is where MISO is sampled (and where
  // the flash samples MOSI); a falling toggle is where MOSI moves on to the
  // next command bit. A completed byte raises byte_ready, which turns into
  // the write strobe one edge later; the address counter advances on the
  // edge after the strobe, so it wraps cleanly past the top of PRAM.
  // Completion is taken on the falling toggle that follows the last sample,
  // which returns flash_clk low together with chip select going high.
  always_ff @(posedge sys_clk) begin
    if (rst) begin
      state        <= IDLE;
      start_q      <= 1'b0;
      div_cnt      <= '0;
      bit_cnt      <= '0;
      cmd_shift    <= '0;
      rx_shift     <= '0;
      rx_bits      <= '0;
      byte_cnt     <= '0;
      byte_ready   <= 1'b0;
      last_byte    <= 1'b0;
      flash_MOSI   <= 1'b0;
      flash_clk    <= 1'b0;
      flash_cs     <= 1'b1;
      pram_wr_en   <= 1'b0;
      pram_wr_addr <= '0;
      pram_wr_data <= '0;
      cpu_hold     <= 1'b1;
      busy         <= 1'b0;
      done         <= 1'b0;
    end else begin
      start_q    <= start;
      pram_wr_en <= 1'b0;

      if (pram_wr_en) begin
        pram_wr_addr <= pram_wr_addr + 1'b1;
      end

      if (byte_ready) begin
        pram_wr_en   <= 1'b1;
        pram_wr_data <= rx_shift;
        byte_ready   <= 1'b0;
      end

      case (state)
        IDLE, DONE: begin
          if (start_q) begin
            state        <= CMD;
            flash_cs     <= 1'b0;
            flash_clk    <= 1'b0;
            flash_MOSI   <= CMD_WORD[31];
            cmd_shift    <= {CMD_WORD[30:0], 1'b0};
            div_cnt      <= '0;
            bit_cnt      <= '0;
            rx_shift     <= '0;
            rx_bits      <= '0;
            byte_cnt     <= '0;
            byte_ready   <= 1'b0;
            last_byte    <= 1'b0;
            pram_wr_addr <= '0;
            cpu_hold     <= 1'b1;
            busy         <= 1'b1;
            done         <= 1'b0;
          end
        end

        CMD, READ: begin
          if (div_cnt != DIV_LAST) begin
            div_cnt <= div_cnt + 1'b1;
          end else begin
            div_cnt <= '0;
            if (!flash_clk) begin
              flash_clk <= 1'b1;
              if (state == CMD) begin
                bit_cnt <= bit_cnt + 1'b1;
              end else begin
                rx_shift <= {rx_shift[6:0], flash_MISO};
                rx_bits  <= rx_bits + 1'b1;
                if (rx_bits == 3'd7) begin
                  byte_ready <= 1'b1;
                  byte_cnt   <= byte_cnt + 1'b1;
                  if (byte_cnt == LAST_BYTE) begin
                    last_byte <= 1'b1;
                  end
                end
              end
            end else begin
              flash_clk <= 1'b0;
              if (state == CMD) begin
                // All 32 command bits have been clocked out, so data follows.
                if (bit_cnt == 6'd32) begin
                  state      <= READ;
                  flash_MOSI <= 1'b0;
                end else begin
                  flash_MOSI <= cmd_shift[31];
                  cmd_shift  <= {cmd_shift[30:0], 1'b0};
                end
              end else if (last_byte) begin
                state     <= DONE;
                flash_cs  <= 1'b1;
                busy      <= 1'b0;
                done      <= 1'b1;
                cpu_hold  <= 1'b0;
                last_byte <= 1'b0;
              end
            end
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_flash_boot_loader.sv
// tb_flash_boot_loader
//
// Drives two loaders: dut_a (8-byte image into a 3-bit PRAM, so the address
// counter wraps, CLK_DIV=2, flash base 0) with a flash model that returns
// byte i = i ^ 8'hA5, and dut_b (4 bytes, CLK_DIV=3, flash base 24'h012340)
// whose MISO is held high so every byte reads 8'hFF.
module tb_flash_boot_loader;

  logic       sys_clk;
  logic       rst;
  logic       start_a;
  logic       start_b;
  bit         sel;

  logic       a_miso = 1'b0;
  logic       a_mosi, a_fclk, a_cs, a_wr_en, a_hold, a_busy, a_done;
  logic [2:0] a_addr;
  logic [7:0] a_data;

  logic       b_miso = 1'b1;
  logic       b_mosi, b_fclk, b_cs, b_wr_en, b_hold, b_busy, b_done;
  logic [7:0] b_addr;
  logic [7:0] b_data;

  logic       cur_mosi, cur_fclk, cur_cs, cur_wr_en, cur_hold, cur_busy, cur_done;
  logic [7:0] cur_addr, cur_data;

  int         checks = 0;
  int         errors = 0;
  logic [15:0] exp_q[$];

  // The flash model tracks its own edge counts between chip selects.
  int         a_fall = 0;
  logic       a_prev_clk = 1'b0;

  flash_boot_loader #(
    .PRAM_AW(3), .LOAD_BYTES(8), .FLASH_BASE(24'h000000), .CLK_DIV(2)
  ) dut_a (
    .sys_clk(sys_clk), .rst(rst), .start(start_a), .flash_MISO(a_miso),
    .flash_MOSI(a_mosi), .flash_clk(a_fclk), .flash_cs(a_cs),
    .pram_wr_en(a_wr_en), .pram_wr_addr(a_addr), .pram_wr_data(a_data),
    .cpu_hold(a_hold), .busy(a_busy), .done(a_done)
  );

  flash_boot_loader #(
    .PRAM_AW(8), .LOAD_BYTES(4), .FLASH_BASE(24'h012340), .CLK_DIV(3)
  ) dut_b (
    .sys_clk(sys_clk), .rst(rst), .start(start_b), .flash_MISO(b_miso),
    .flash_MOSI(b_mosi), .flash_clk(b_fclk), .flash_cs(b_cs),
    .pram_wr_en(b_wr_en), .pram_wr_addr(b_addr), .pram_wr_data(b_data),
    .cpu_hold(b_hold), .busy(b_busy), .done(b_done)
  );

  assign cur_mosi  = sel ? b_mosi  : a_mosi;
  assign cur_fclk  = sel ? b_fclk  : a_fclk;
  assign cur_cs    = sel ? b_cs    : a_cs;
  assign cur_wr_en = sel ? b_wr_en : a_wr_en;
  assign cur_hold  = sel ? b_hold  : a_hold;
  assign cur_busy  = sel ? b_busy  : a_busy;
  assign cur_done  = sel ? b_done  : a_done;
  assign cur_addr  = sel ? b_addr  : {5'b0, a_addr};
  assign cur_data  = sel ? b_data  : a_data;

  initial sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  // Flash for dut_a: after the 32 command/address bits, each falling
  // flash_clk presents the next image bit (MSB first) for the next rise.
  always @(negedge sys_clk) begin
    int idx;
    if (a_cs === 1'b1) begin
      a_fall = 0;
    end else if (a_prev_clk === 1'b1 && a_fclk === 1'b0) begin
      a_fall++;
      if (a_fall >= 32) begin
        idx = a_fall - 32;
        if (idx < 64) begin
          a_miso = 8'((idx / 8) ^ 8'hA5) >> (7 - (idx % 8)) & 8'h01;
        end
      end
    end
    a_prev_clk = a_fclk;
  end

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("[TB] FAIL %s got=0x%0h expected=0x%0h", tag, got, want);
    end
  endtask

  task automatic drive_start(input logic v);
    if (sel) start_b = v;
    else     start_a = v;
  endtask

  // Queue the writes this load should produce, then pulse start once.
  task automatic applyStimulus(input int n_bytes);
    for (int i = 0; i < n_bytes; i++) begin
      if (sel) exp_q.push_back({8'(i), 8'hFF});
      else     exp_q.push_back({8'(i), 8'(i) ^ 8'hA5});
    end
    @(posedge sys_clk); #1;
    drive_start(1'b1);
    @(posedge sys_clk); #1;
    drive_start(1'b0);
  endtask

  // Follows one load cycle by cycle from the edge after start was taken,
  // scoring every write strobe against the queue as it appears.
  task automatic wait_load(input int extra_start_at, input int stop_after,
                           output int latency, output int first_rise,
                           output int second_rise, output logic [31:0] cmd_seen,
                           output int strobes, output logic read_mosi_high);
    int          rises;
    logic        prev_clk;
    logic [15:0] e;
    rises = 0; prev_clk = 1'b0; latency = -1; first_rise = -1; second_rise = -1;
    cmd_seen = '0; strobes = 0; read_mosi_high = 1'b0;
    for (int n = 1; n <= 4000; n++) begin
      @(posedge sys_clk); #1;
      if (n == 1) begin
        checkOutput("entry_cs",   32'(cur_cs),   0);
        checkOutput("entry_busy", 32'(cur_busy), 1);
        checkOutput("entry_hold", 32'(cur_hold), 1);
        checkOutput("entry_done", 32'(cur_done), 0);
      end
      if (n == extra_start_at)     drive_start(1'b1);
      if (n == extra_start_at + 1) drive_start(1'b0);
      if (!prev_clk && cur_fclk) begin
        rises++;
        if (rises == 1) first_rise = n;
        if (rises == 2) second_rise = n;
        if (rises <= 32) cmd_seen = {cmd_seen[30:0], cur_mosi};
        else if (cur_mosi) read_mosi_high = 1'b1;
      end
      prev_clk = cur_fclk;
      if (cur_wr_en) begin
        strobes++;
        if (exp_q.size() == 0) begin
          checkOutput("extra_write", 32'(cur_addr), 32'hFFFF);
        end else begin
          e = exp_q.pop_front();
          checkOutput("wr_addr", 32'(cur_addr), 32'(e[15:8]));
          checkOutput("wr_data", 32'(cur_data), 32'(e[7:0]));
        end
      end
      if (stop_after > 0 && strobes == stop_after) break;
      if (cur_done) begin
        latency = n;
        break;
      end
    end
  endtask

  initial begin
    int          lat, r1, r2, nstr, extra;
    logic [31:0] cmd;
    logic        mh, clk_seen, cs_low;

    rst = 1'b1; start_a = 1'b0; start_b = 1'b0; sel = 1'b0;
    clk_seen = 1'b0;

    // Reset held for four cycles.
    repeat (4) begin
      @(posedge sys_clk); #1;
      clk_seen = clk_seen | a_fclk | b_fclk;
    end
    checkOutput("rst_cs",    32'(a_cs),     1);
    checkOutput("rst_clk",   32'(clk_seen), 0);
    checkOutput("rst_mosi",  32'(a_mosi),   0);
    checkOutput("rst_wr_en", 32'(a_wr_en),  0);
    checkOutput("rst_addr",  32'(a_addr),   0);
    checkOutput("rst_data",  32'(a_data),   0);
    checkOutput("rst_hold",  32'(a_hold),   1);
    checkOutput("rst_busy",  32'(a_busy),   0);
    checkOutput("rst_done",  32'(a_done),   0);
    checkOutput("rst_b_cs",  32'(b_cs),     1);
    rst = 1'b0;

    // Full load on dut_a.
    $display("[TB] full load");
    applyStimulus(8);
    wait_load(-1, 0, lat, r1, r2, cmd, nstr, mh);
    checkOutput("full_latency", lat, 385);
    checkOutput("full_strobes", nstr, 8);
    checkOutput("full_cmd", cmd, 32'h03000000);
    checkOutput("full_read_mosi", 32'(mh), 0);
    checkOutput("full_rise1", r1, 3);
    checkOutput("full_rise2", r2, 7);
    checkOutput("full_cs", 32'(a_cs), 1);
    checkOutput("full_clk", 32'(a_fclk), 0);
    checkOutput("full_busy", 32'(a_busy), 0);
    checkOutput("full_hold", 32'(a_hold), 0);
    checkOutput("full_addr_wrap", 32'(a_addr), 0);
    checkOutput("full_exp_left", exp_q.size(), 0);

    // Reload from DONE, with a stray start pulse in the middle of READ.
    $display("[TB] reload with busy start");
    applyStimulus(8);
    wait_load(200, 0, lat, r1, r2, cmd, nstr, mh);
    checkOutput("reload_latency", lat, 385);
    checkOutput("reload_strobes", nstr, 8);
    checkOutput("reload_hold", 32'(a_hold), 0);
    checkOutput("reload_exp_left", exp_q.size(), 0);

    // Reset after three bytes have been written.
    $display("[TB] reset mid-read");
    applyStimulus(8);
    wait_load(-1, 3, lat, r1, r2, cmd, nstr, mh);
    checkOutput("midrst_strobes", nstr, 3);
    rst = 1'b1;
    @(posedge sys_clk); #1;
    rst = 1'b0;
    checkOutput("midrst_cs", 32'(a_cs), 1);
    checkOutput("midrst_clk", 32'(a_fclk), 0);
    checkOutput("midrst_hold", 32'(a_hold), 1);
    checkOutput("midrst_busy", 32'(a_busy), 0);
    exp_q.delete();
    extra = 0; cs_low = 1'b0;
    repeat (100) begin
      @(posedge sys_clk); #1;
      if (a_wr_en) extra++;
      cs_low = cs_low | ~a_cs;
    end
    checkOutput("midrst_no_writes", extra, 0);
    checkOutput("midrst_cs_idle", 32'(cs_low), 0);
    applyStimulus(8);
    wait_load(-1, 0, lat, r1, r2, cmd, nstr, mh);
    checkOutput("restart_cmd", cmd, 32'h03000000);
    checkOutput("restart_strobes", nstr, 8);
    checkOutput("restart_latency", lat, 385);

    // dut_b: slower SPI clock and a non-zero flash base.
    $display("[TB] clk_div 3");
    sel = 1'b1;
    applyStimulus(4);
    wait_load(-1, 0, lat, r1, r2, cmd, nstr, mh);
    checkOutput("div3_rise1", r1, 4);
    checkOutput("div3_period", r2 - r1, 6);
    checkOutput("div3_cmd", cmd, 32'h03012340);
    checkOutput("div3_strobes", nstr, 4);
    checkOutput("div3_latency", lat, 385);
    checkOutput("div3_addr", 32'(b_addr), 4);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
